// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants: next-PC select codes, ALU ops, NOP, fetch FSM states
package cpu_pkg;

  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_JREG   = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory req/ack bus between fetch unit and memory
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection and JR misalignment detect
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [2:0]  pc_control,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] seq_pc;
  logic [31:0] branch_off;

  always_comb begin
    seq_pc     = pc + 32'd4;
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    misalign   = 1'b0;
    case (pc_control)
      PC_JUMP:   next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
      PC_JREG: begin
        next_pc  = {rs_data[31:2], 2'b00};
        misalign = |rs_data[1:0];
      end
      PC_BRANCH: next_pc = seq_pc + branch_off;
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and instruction fetch FSM (IDLE/FETCH/HOLD)
// Optional retired-instruction counter enabled by IFETCH_INSTR_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  imem,
  input  logic [2:0]     pc_control,
  input  logic [31:0]    rs_data,
  input  logic           exec_ready,
  output logic [31:0]    instr,
  output logic           instr_valid,
  output logic [31:0]    pc,
  output logic [31:0]    pc_plus4,
  output logic           misalign_err,
  output logic [31:0]    instr_cnt
);

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        jr_misalign;
  logic        advance;

  next_pc_calc u_next_pc (
    .pc         (pc_q),
    .instr      (instr_q),
    .rs_data    (rs_data),
    .pc_control (pc_control),
    .next_pc    (next_pc),
    .misalign   (jr_misalign)
  );

  // Decoder outputs are only trusted while a valid instruction sits in HOLD.
  assign advance = (state_q == ST_HOLD) && valid_q && exec_ready;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          pc_d       = next_pc;
          addr_d     = next_pc;
          valid_d    = 1'b0;
          req_d      = 1'b1;
          misalign_d = jr_misalign;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef IFETCH_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && exec_ready) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = 32'd0;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a transaction-level model
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_control;
  logic [31:0] rs_data;
  logic        exec_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] instr_cnt;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus),
    .pc_control   (pc_control),
    .rs_data      (rs_data),
    .exec_ready   (exec_ready),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err),
    .instr_cnt    (instr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  int unsigned exp_cnt;
  logic [31:0] mem_over [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0F0F;
  endfunction

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [2:0] ctl, input logic [31:0] cur_pc,
                                           input logic [31:0] ins, input logic [31:0] rs);
    int off;
    case (ctl)
      3'd1: return ((cur_pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      3'd2: return rs & 32'hFFFF_FFFC;
      3'd3: begin
        off = $signed(ins[15:0]);
        return cur_pc + 32'd4 + 32'(off * 4);
      end
      default: return cur_pc + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] cnt_expect();
`ifdef IFETCH_INSTR_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_fetch(input int wait_cycles);
    int n;
    n = 0;
    while (!bus.imem_req && n < 10) begin
      exec_ready = 1'($urandom);
      pc_control = 3'($urandom);
      step();
      n++;
    end
    check("req_rise", 32'(bus.imem_req), 32'd1);
    check("fetch_addr", bus.imem_addr, exp_pc);
    repeat (wait_cycles) begin
      exec_ready = 1'($urandom);
      step();
      check("req_hold", 32'(bus.imem_req), 32'd1);
      check("addr_hold", bus.imem_addr, exp_pc);
    end
    exp_instr = mem_word(exp_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = exp_instr;
    exec_ready     = 1'($urandom);
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    exec_ready     = 1'b0;
    check("valid_rise", 32'(instr_valid), 32'd1);
    check("instr", instr, exp_instr);
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check("req_drop", 32'(bus.imem_req), 32'd0);
  endtask

  task automatic consume(input logic [2:0] ctl, input logic [31:0] rs, input int hold);
    logic [31:0] nxt;
    logic        mis;
    repeat (hold) begin
      exec_ready     = 1'b0;
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      step();
      check("hold_instr", instr, exp_instr);
      check("hold_pc", pc, exp_pc);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    bus.imem_ack = 1'b0;
    pc_control   = ctl;
    rs_data      = rs;
    exec_ready   = 1'b1;
    nxt = ref_next(ctl, exp_pc, exp_instr, rs);
    mis = (ctl == 3'd2) && (rs[1:0] != 2'b00);
    step();
    exp_cnt++;
    exec_ready = 1'b0;
    pc_control = 3'($urandom);
    rs_data    = $urandom;
    check("adv_valid", 32'(instr_valid), 32'd0);
    check("adv_req", 32'(bus.imem_req), 32'd1);
    check("adv_addr", bus.imem_addr, nxt);
    check("adv_pc", pc, nxt);
    check("misalign", 32'(misalign_err), 32'(mis));
    check("instr_cnt", instr_cnt, cnt_expect());
    step();
    check("misalign_end", 32'(misalign_err), 32'd0);
    exp_pc = nxt;
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_control     = 3'd0;
    rs_data        = 32'd0;
    exec_ready     = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    exp_pc         = 32'h0;
    exp_instr      = NOP_INSTR;
    exp_cnt        = 0;
    mem_over[32'h0040_0010] = 32'h0810_0040;
    mem_over[32'h0000_0020] = 32'h1000_FFFE;

    repeat (3) step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);

    rst_n = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("idle_ack_ignored", 32'(instr_valid), 32'd0);

    do_fetch(2);
    for (int i = 0; i < 3; i++) begin
      consume(3'd0, $urandom, 0);
      do_fetch(2);
    end
    check("seq_addr_12", pc, 32'h0000_000C);

    consume(3'd2, 32'h0040_0010, 0);
    do_fetch(1);
    consume(3'd1, $urandom, 0);
    check("jump_target", pc, 32'h0040_0100);
    do_fetch(0);

    consume(3'd2, 32'h0000_0020, 1);
    do_fetch(0);
    consume(3'd3, $urandom, 0);
    check("branch_target", pc, 32'h0000_001C);
    do_fetch(2);

    consume(3'd2, 32'h0000_1003, 0);
    check("jr_aligned", pc, 32'h0000_1000);
    do_fetch(3);

    consume(3'd0, 32'd0, 5);
    do_fetch(1);

    consume(3'd2, 32'hFFFF_FFFC, 0);
    do_fetch(0);
    consume(3'd0, 32'd0, 0);
    check("wrap", pc, 32'h0);
    do_fetch(1);

    for (int i = 0; i < 150; i++) begin
      consume(3'($urandom), $urandom, int'($urandom_range(0, 3)));
      do_fetch(int'($urandom_range(0, 3)));
    end

    consume(3'($urandom), $urandom, 0);
    step();
    rst_n = 1'b0;
    #1;
    check("midfetch_req", 32'(bus.imem_req), 32'd0);
    check("midfetch_pc", pc, 32'h0);
    check("midfetch_valid", 32'(instr_valid), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("late_ack_ignored", 32'(instr_valid), 32'd0);
    exp_pc  = 32'h0;
    exp_cnt = 0;
    check("cnt_after_reset", instr_cnt, 32'd0);
    do_fetch(1);
    consume(3'd0, 32'd0, 0);
    do_fetch(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end of the single-issue MIPS core: owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents `instr` to the decoder.
- Consumes the decoder's `pc_control` code, together with the register value for JR, to form the next PC.
- This is the producer of `instr` and the consumer of `pc_control`, i.e. the other end of the decoder interface.
- No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_control  in  3  next-PC select from decoder: 000 seq, 001 jump, 010 jump-register, 011 branch taken, others treated as 000
- rs_data  in  32  register-file rs value; JR target
- exec_ready  in  1  core consumes current instruction this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address, word aligned
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr  out  32  current instruction to decoder
- instr_valid  out  1  instr/pc valid
- pc  out  32  address of current instr
- pc_plus4  out  32  pc+4; JAL link value
- misalign_err  out  1  one-cycle pulse: JR target low bits nonzero
- instr_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset state (asynchronous, immediate):
  - imem_req=0, imem_addr=RESET_PC
  - pc=RESET_PC, instr=32'h0 (SLL NOP), instr_valid=0
  - misalign_err=0, instr_cnt=0
  - FSM in IDLE
- FSM states:
  - IDLE: unconditionally go to FETCH next cycle, with imem_req=1 and imem_addr=pc.
  - FETCH:
    - imem_req held 1 and imem_addr held stable until the cycle imem_ack=1.
    - On ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
    - Ack-to-valid latency is 1 cycle.
  - HOLD:
    - instr, pc and instr_valid are held stable.
    - pc_control and rs_data are sampled only in a cycle where instr_valid=1 and exec_ready=1; they are combinationally valid that cycle.
    - In that cycle: pc<=next_pc, imem_addr<=next_pc, instr_valid<=0, imem_req<=1, go to FETCH.
    - Result: one instruction per 2+N cycles, where N is the memory wait.
- next_pc, computed from the current pc and instr:
  - 000 / undefined: pc+4
  - 001: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 010: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0, misalign_err pulses for the advance cycle+1.
  - 011: pc+4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32
- pc_plus4 = pc+4 combinationally.
- Boundary conditions:
  - Address arithmetic wraps at 2^32; 32'hFFFF_FFFC + 4 = 0.
  - imem_ack in IDLE or HOLD is ignored (stale ack after mid-fetch reset).
  - exec_ready while instr_valid=0 is ignored.
  - Reset asserted mid-FETCH drops imem_req in the same cycle.
  - The first fetch after release is at RESET_PC.
  - Back-to-back exec_ready never skips an instruction.

Optional Feature:
- Macro: IFETCH_INSTR_CNT_EN.
- Defined: instr_cnt increments by 1 (wrapping at 2^32) in every cycle with instr_valid=1 and exec_ready=1.
- Undefined: no counter register; instr_cnt tied to 0; port list unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SEQ=3'b000, PC_JUMP=3'b001, PC_JREG=3'b010, PC_BRANCH=3'b011
  - ALU op constants, shared with the decoder
  - NOP_INSTR=32'h0
  - FSM state encoding
- One natural combinational sub-module, next_pc_calc: inputs pc, instr, rs_data, pc_control; outputs next_pc, misalign.
- instr_fetch keeps the FSM and registers.

Test Plan:
- Reset release, memory acks at 2-cycle wait:
  - First imem_addr=0, instr_valid rises 1 cycle after ack.
  - With pc_control=000 and exec_ready=1: next addresses are 4, 8, 12.
- pc=32'h0040_0010, instr=32'h0810_0040 (J), pc_control=001 → next imem_addr=32'h0040_0100.
- pc=32'h0000_0020, imm=16'hFFFE, pc_control=011 → next addr 32'h0000_001C.
- pc_control=010, rs_data=32'h0000_1003 → imem_addr=32'h0000_1000 and misalign_err pulses exactly one cycle.
- Reset asserted mid-FETCH → imem_req=0 immediately; a late ack is ignored; refetch at RESET_PC.
- exec_ready=0 for 5 cycles in HOLD → instr and pc stable, no req.
- With IFETCH_INSTR_CNT_EN defined: instr_cnt=3 after three consumes; with it undefined, instr_cnt=0.
